lb_block_sequencer: RTL and testbench

//  Controller for the 8x8 transpose line buffer (8 rows of 8 x 12-bit pixels in, 8 columns out).

---
 rtl/lb_block_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_lb_block_sequencer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lb_block_sequencer.sv
// Sequencer for the 8x8 transpose line buffer: alternates FILL (8 row writes) and
// DRAIN (8 column reads) per block and walks the block raster across the frame.
module lb_block_sequencer #(
  parameter int IMG_W = 1920,
  parameter int IMG_H = 1080,
  parameter int BX_W  = 8,
  parameter int BY_W  = 8
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic            i_abort,
  input  logic            i_in_valid,
  output logic            o_in_ready,
  output logic            o_out_valid,
  input  logic            i_out_ready,
  output logic            o_lb_write,
  output logic            o_lb_read,
  output logic            o_lb_clr,
  output logic [BX_W-1:0] o_blk_x,
  output logic [BY_W-1:0] o_blk_y,
  output logic            o_blk_last,
  output logic            o_busy,
  output logic            o_done
);

  localparam logic [BX_W-1:0] BX_MAX = BX_W'(IMG_W / 8 - 1);
  localparam logic [BY_W-1:0] BY_MAX = BY_W'(IMG_H / 8 - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      row_cnt_q, row_cnt_d;
  logic [2:0]      col_cnt_q, col_cnt_d;
  logic [BX_W-1:0] blk_x_q, blk_x_d;
  logic [BY_W-1:0] blk_y_q, blk_y_d;
  logic            last_s;

  assign last_s  = (blk_x_q == BX_MAX) && (blk_y_q == BY_MAX);
  assign o_blk_x = blk_x_q;
  assign o_blk_y = blk_y_q;

  // State and counter registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      row_cnt_q <= 3'd0;
      col_cnt_q <= 3'd0;
      blk_x_q   <= {BX_W{1'b0}};
      blk_y_q   <= {BY_W{1'b0}};
    end else begin
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
      col_cnt_q <= col_cnt_d;
      blk_x_q   <= blk_x_d;
      blk_y_q   <= blk_y_d;
    end
  end

  // Next-state, row/column counting and block raster advance
  always_comb begin
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    col_cnt_d = col_cnt_q;
    blk_x_d   = blk_x_q;
    blk_y_d   = blk_y_q;
    if (i_abort && (state_q != S_IDLE)) begin
      // Abandon the frame outright; any partially filled block is dropped.
      state_d   = S_IDLE;
      row_cnt_d = 3'd0;
      col_cnt_d = 3'd0;
      blk_x_d   = {BX_W{1'b0}};
      blk_y_d   = {BY_W{1'b0}};
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_start && !i_abort) begin
            state_d   = S_FILL;
            row_cnt_d = 3'd0;
            col_cnt_d = 3'd0;
            blk_x_d   = {BX_W{1'b0}};
            blk_y_d   = {BY_W{1'b0}};
          end else begin
            state_d = S_IDLE;
          end
        end
        S_FILL: begin
          if (i_in_valid) begin
            if (row_cnt_q == 3'd7) begin
              state_d   = S_DRAIN;
              row_cnt_d = 3'd0;
            end else begin
              row_cnt_d = row_cnt_q + 3'd1;
            end
          end else begin
            state_d = S_FILL;
          end
        end
        S_DRAIN: begin
          if (i_out_ready) begin
            if (col_cnt_q == 3'd7) begin
              col_cnt_d = 3'd0;
              if (last_s) begin
                state_d = S_DONE;
              end else begin
                state_d = S_FILL;
                if (blk_x_q == BX_MAX) begin
                  blk_x_d = {BX_W{1'b0}};
                  blk_y_d = blk_y_q + BY_W'(1);
                end else begin
                  blk_x_d = blk_x_q + BX_W'(1);
                end
              end
            end else begin
              col_cnt_d = col_cnt_q + 3'd1;
            end
          end else begin
            state_d = S_DRAIN;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
          blk_x_d = {BX_W{1'b0}};
          blk_y_d = {BY_W{1'b0}};
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Handshake and buffer-control outputs; write/read follow the handshakes with zero latency
  always_comb begin
    o_in_ready  = 1'b0;
    o_out_valid = 1'b0;
    o_lb_write  = 1'b0;
    o_lb_read   = 1'b0;
    o_lb_clr    = 1'b0;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    o_blk_last  = 1'b0;
    if (i_rst) begin
      o_lb_clr = 1'b1;
    end else begin
      o_blk_last = last_s;
      case (state_q)
        S_IDLE: begin
          o_lb_clr = i_start & ~i_abort;
        end
        S_FILL: begin
          o_busy     = 1'b1;
          o_in_ready = 1'b1;
          o_lb_clr   = i_abort;
          o_lb_write = i_in_valid & ~i_abort;
        end
        S_DRAIN: begin
          o_busy      = 1'b1;
          o_out_valid = 1'b1;
          o_lb_clr    = i_abort;
          o_lb_read   = i_out_ready & ~i_abort;
        end
        S_DONE: begin
          o_busy   = 1'b1;
          o_lb_clr = i_abort;
          o_done   = ~i_abort;
        end
        default: begin
          o_busy = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lb_block_sequencer.sv
// Scoreboard bench for lb_block_sequencer: a behavioural 8x8 transpose buffer is driven by
// the DUT's write/read/clear, and every drained column is checked against the transposed rows.
module tb_lb_block_sequencer;
  localparam int IMG_W = 32;
  localparam int IMG_H = 16;
  localparam int BX_W  = 8;
  localparam int BY_W  = 8;
  localparam int BXN   = IMG_W / 8;
  localparam int BYN   = IMG_H / 8;
  localparam int NB    = BXN * BYN;

  logic i_clk = 1'b0;
  logic i_rst, i_start, i_abort, i_in_valid, i_out_ready;
  logic o_in_ready, o_out_valid, o_lb_write, o_lb_read, o_lb_clr;
  logic [BX_W-1:0] o_blk_x;
  logic [BY_W-1:0] o_blk_y;
  logic o_blk_last, o_busy, o_done;

  logic [11:0] row_data [8];
  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  bit rdy_rand = 1'b0;

  typedef struct {
    logic [95:0] col;
    int          bx;
    int          by;
    bit          last;
  } exp_t;
  exp_t sbq[$];

  always #5 i_clk = ~i_clk;

  lb_block_sequencer #(.IMG_W(IMG_W), .IMG_H(IMG_H), .BX_W(BX_W), .BY_W(BY_W)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_abort(i_abort),
    .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .o_out_valid(o_out_valid),
    .i_out_ready(i_out_ready), .o_lb_write(o_lb_write), .o_lb_read(o_lb_read),
    .o_lb_clr(o_lb_clr), .o_blk_x(o_blk_x), .o_blk_y(o_blk_y), .o_blk_last(o_blk_last),
    .o_busy(o_busy), .o_done(o_done)
  );

  // Behavioural transpose buffer: rows written in, column pointer advanced on read
  logic [11:0] mem [8][8];
  int wp = 0;
  int rp = 0;
  always @(posedge i_clk) begin
    if (o_lb_clr) begin
      wp <= 0;
      rp <= 0;
    end else begin
      if (o_lb_write) begin
        for (int c = 0; c < 8; c++) mem[wp][c] <= row_data[c];
        wp <= (wp + 1) % 8;
      end
      if (o_lb_read) rp <= (rp + 1) % 8;
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Monitor: per-cycle invariants and scoreboard pops on each column handshake
  initial begin
    exp_t e;
    logic [95:0] act;
    forever begin
      @(negedge i_clk);
      if (!i_rst) begin
        chk("wr_rd_excl", 128'(o_lb_write & o_lb_read), 128'd0);
        chk("rdy_vld_excl", 128'(o_in_ready & o_out_valid), 128'd0);
        chk("write_hs", 128'(o_lb_write), 128'(i_in_valid & o_in_ready & ~i_abort));
        chk("read_hs", 128'(o_lb_read), 128'(o_out_valid & i_out_ready & ~i_abort));
        if (o_out_valid && i_out_ready && !i_abort) begin
          if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_column: got column at blk (%0d,%0d) expected none", o_blk_x, o_blk_y);
          end else begin
            e = sbq.pop_front();
            for (int r = 0; r < 8; r++) act[r*12 +: 12] = mem[r][rp];
            chk("column_data", 128'(act), 128'(e.col));
            chk("blk_x", 128'(o_blk_x), 128'(e.bx));
            chk("blk_y", 128'(o_blk_y), 128'(e.by));
            chk("blk_last", 128'(o_blk_last), 128'(e.last));
          end
        end
        if (o_done) done_cnt++;
      end
    end
  end

  // Downstream ready: constant high or randomly gapped
  initial begin
    i_out_ready = 1'b1;
    forever begin
      @(posedge i_clk);
      #1;
      i_out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic send_row(input logic [95:0] d);
    int n = $urandom_range(0, 2);
    bit got = 1'b0;
    i_in_valid = 1'b0;
    repeat (n) tick();
    for (int c = 0; c < 8; c++) row_data[c] = d[c*12 +: 12];
    i_in_valid = 1'b1;
    for (int t = 0; t < 300 && !got; t++) begin
      @(negedge i_clk);
      if (o_in_ready) got = 1'b1;
      tick();
    end
    i_in_valid = 1'b0;
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL row_accept: got no o_in_ready expected acceptance within 300 cycles");
    end
  endtask

  // Reference: block k of the raster sits at (k % BXN, k / BXN); column c is pixel c of every row
  task automatic send_block(input int k, input int nrows);
    logic [95:0] rows [8];
    exp_t e;
    for (int r = 0; r < nrows; r++) begin
      for (int c = 0; c < 8; c++) rows[r][c*12 +: 12] = 12'($urandom);
      send_row(rows[r]);
    end
    if (nrows == 8) begin
      for (int c = 0; c < 8; c++) begin
        for (int r = 0; r < 8; r++) e.col[r*12 +: 12] = rows[r][c*12 +: 12];
        e.bx = k % BXN;
        e.by = k / BXN;
        e.last = (k == NB - 1);
        sbq.push_back(e);
      end
    end
  endtask

  task automatic run_frame(input bit hold_start);
    int d0 = done_cnt;
    bit seen = 1'b0;
    i_start = 1'b1;
    @(negedge i_clk);
    chk("start_clr", 128'(o_lb_clr), 128'd1);
    tick();
    if (!hold_start) i_start = 1'b0;
    for (int k = 0; k < NB; k++) send_block(k, 8);
    i_start = 1'b0;
    for (int t = 0; t < 400 && !seen; t++) begin
      @(negedge i_clk);
      if (o_done) begin
        seen = 1'b1;
        chk("last_at_done", 128'(o_blk_last), 128'd1);
      end
      tick();
    end
    chk("done_seen", 128'(seen), 128'd1);
    chk("done_once", 128'(done_cnt - d0), 128'd1);
    chk("sb_drained", 128'(sbq.size()), 128'd0);
    @(negedge i_clk);
    chk("idle_after_done", 128'(o_busy), 128'd0);
    chk("blk_x_cleared", 128'(o_blk_x), 128'd0);
    chk("blk_y_cleared", 128'(o_blk_y), 128'd0);
    tick();
  endtask

  initial begin
    exp_t e;
    int d0;
    i_rst = 1'b1; i_start = 1'b0; i_abort = 1'b0; i_in_valid = 1'b0;
    for (int c = 0; c < 8; c++) row_data[c] = 12'd0;
    tick();
    @(negedge i_clk);
    chk("rst_clr", 128'(o_lb_clr), 128'd1);
    chk("rst_busy", 128'(o_busy), 128'd0);
    chk("rst_in_ready", 128'(o_in_ready), 128'd0);
    chk("rst_out_valid", 128'(o_out_valid), 128'd0);
    chk("rst_done", 128'(o_done), 128'd0);
    tick();
    i_rst = 1'b0;
    @(negedge i_clk);
    chk("post_rst_clr", 128'(o_lb_clr), 128'd0);
    chk("post_rst_blk_x", 128'(o_blk_x), 128'd0);
    chk("post_rst_blk_y", 128'(o_blk_y), 128'd0);
    chk("post_rst_in_ready", 128'(o_in_ready), 128'd0);
    tick();

    // Back-to-back block: 8 write cycles, then 8 read cycles, then blk_x advances
    i_start = 1'b1;
    @(negedge i_clk);
    chk("t1_start_clr", 128'(o_lb_clr), 128'd1);
    tick();
    i_start = 1'b0;
    for (int c = 0; c < 8; c++) begin
      for (int r = 0; r < 8; r++) e.col[r*12 +: 12] = 12'(r * 8 + c);
      e.bx = 0; e.by = 0; e.last = 1'b0;
      sbq.push_back(e);
    end
    i_in_valid = 1'b1;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) row_data[c] = 12'(r * 8 + c);
      @(negedge i_clk);
      chk("t1_write", 128'(o_lb_write), 128'd1);
      chk("t1_no_read", 128'(o_lb_read), 128'd0);
      tick();
    end
    i_in_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge i_clk);
      chk("t1_read", 128'(o_lb_read), 128'd1);
      chk("t1_blk_x0", 128'(o_blk_x), 128'd0);
      tick();
    end
    @(negedge i_clk);
    chk("t1_blk_x1", 128'(o_blk_x), 128'd1);
    chk("t1_refill", 128'(o_in_ready), 128'd1);
    tick();
    i_abort = 1'b1;
    @(negedge i_clk);
    chk("t1_abort_clr", 128'(o_lb_clr), 128'd1);
    tick();
    i_abort = 1'b0;
    @(negedge i_clk);
    chk("t1_abort_idle", 128'(o_busy), 128'd0);
    tick();

    rdy_rand = 1'b1;
    run_frame(1'b0);
    run_frame(1'b1);

    // Abort after 5 rows of block (3,0)
    d0 = done_cnt;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int k = 0; k < 3; k++) send_block(k, 8);
    send_block(3, 5);
    i_in_valid = 1'b1;
    i_abort = 1'b1;
    @(negedge i_clk);
    chk("ab_blk_x", 128'(o_blk_x), 128'd3);
    chk("ab_blk_y", 128'(o_blk_y), 128'd0);
    chk("ab_clr", 128'(o_lb_clr), 128'd1);
    chk("ab_no_write", 128'(o_lb_write), 128'd0);
    chk("ab_no_done", 128'(o_done), 128'd0);
    tick();
    i_abort = 1'b0;
    i_in_valid = 1'b0;
    @(negedge i_clk);
    chk("ab_idle", 128'(o_busy), 128'd0);
    chk("ab_in_ready", 128'(o_in_ready), 128'd0);
    chk("ab_blk_x0", 128'(o_blk_x), 128'd0);
    chk("ab_blk_y0", 128'(o_blk_y), 128'd0);
    chk("ab_sb_empty", 128'(sbq.size()), 128'd0);
    chk("ab_done_cnt", 128'(done_cnt - d0), 128'd0);
    tick();
    run_frame(1'b0);

    // Start and abort together in IDLE: stays IDLE
    i_start = 1'b1;
    i_abort = 1'b1;
    @(negedge i_clk);
    chk("sa_busy", 128'(o_busy), 128'd0);
    tick();
    i_start = 1'b0;
    i_abort = 1'b0;
    @(negedge i_clk);
    chk("sa_stay_idle", 128'(o_busy), 128'd0);
    chk("sa_in_ready", 128'(o_in_ready), 128'd0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
